// File: rtl/hazard_ctrl.sv
// Stall/bubble/flush controller for the 5-stage rv32i pipeline: load-use bubbles,
// memory freezes and redirect flushes. Optional perf counters behind HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  ifid_uses_rs1,
    input  logic                  ifid_uses_rs2,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  ex_br_taken,
    input  logic                  imem_req,
    input  logic                  imem_resp,
    input  logic                  dmem_req,
    input  logic                  dmem_resp,
    output logic                  pc_load,
    output logic                  ifid_load,
    output logic                  idex_load,
    output logic                  exmem_load,
    output logic                  memwb_load,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic [1:0]            stall_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]     perf_mem_stall,
    output logic [PERF_W-1:0]     perf_lu_bubble,
    output logic [PERF_W-1:0]     perf_flush
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        LU_BUBBLE = 2'd2
    } stallState_e;

    if (PERF_W < 1) begin : gPerfWidthCheck
        $error("hazard_ctrl: PERF_W must be at least 1");
    end

    stallState_e state_q, state_d;
    logic        imemDone_q, imemDone_d;
    logic        dmemDone_q, dmemDone_d;
    logic        bubbleDone_q, bubbleDone_d;

    logic iRdy, dRdy, memStall;
    logic luHazard, luMasked, luTake, brTake;

    // A response that arrived on an earlier stalled cycle still counts as ready.
    assign iRdy     = !imem_req | imem_resp | imemDone_q;
    assign dRdy     = !dmem_req | dmem_resp | dmemDone_q;
    assign memStall = !(iRdy & dRdy);

    assign luHazard = idex_mem_read && (idex_rd != '0) &&
                      ((ifid_uses_rs1 && (ifid_rs1 == idex_rd)) ||
                       (ifid_uses_rs2 && (ifid_rs2 == idex_rd)));

    // Once the bubble is in, the consumer may advance; that also holds across a freeze.
    assign luMasked = (state_q == LU_BUBBLE) || ((state_q == MEM_WAIT) && bubbleDone_q);
    assign brTake   = !memStall && ex_br_taken;
    assign luTake   = !memStall && !ex_br_taken && luHazard && !luMasked;

    assign stall_state = state_q;

    always_comb begin
        state_d      = RUN;
        bubbleDone_d = 1'b0;
        imemDone_d   = 1'b0;
        dmemDone_d   = 1'b0;
        if (memStall) begin
            state_d      = MEM_WAIT;
            bubbleDone_d = bubbleDone_q || (state_q == LU_BUBBLE);
            imemDone_d   = imemDone_q || imem_resp;
            dmemDone_d   = dmemDone_q || dmem_resp;
        end else if (luTake) begin
            state_d = LU_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            imemDone_q   <= 1'b0;
            dmemDone_q   <= 1'b0;
            bubbleDone_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            imemDone_q   <= imemDone_d;
            dmemDone_q   <= dmemDone_d;
            bubbleDone_q <= bubbleDone_d;
        end
    end

    // Enables stay low for the whole reset window, even with no stall pending.
    always_comb begin
        pc_load    = 1'b0;
        ifid_load  = 1'b0;
        idex_load  = 1'b0;
        exmem_load = 1'b0;
        memwb_load = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (rst_n && !memStall) begin
            idex_load  = 1'b1;
            exmem_load = 1'b1;
            memwb_load = 1'b1;
            if (brTake) begin
                pc_load    = 1'b1;
                ifid_load  = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (luTake) begin
                idex_flush = 1'b1;
            end else begin
                pc_load    = 1'b1;
                ifid_load  = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perfMemStall_q, perfLuBubble_q, perfFlush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfMemStall_q <= '0;
            perfLuBubble_q <= '0;
            perfFlush_q    <= '0;
        end else begin
            if (memStall && (perfMemStall_q != '1)) begin
                perfMemStall_q <= perfMemStall_q + 1'b1;
            end
            if (luTake && (perfLuBubble_q != '1)) begin
                perfLuBubble_q <= perfLuBubble_q + 1'b1;
            end
            if (brTake && (perfFlush_q != '1)) begin
                perfFlush_q <= perfFlush_q + 1'b1;
            end
        end
    end

    assign perf_mem_stall = perfMemStall_q;
    assign perf_lu_bubble = perfLuBubble_q;
    assign perf_flush     = perfFlush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, x0/non-use, split responses, redirect
// under stall, bubble masking across a freeze, reset mid-stall and perf counters.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
    logic       ifid_uses_rs1 = 0, ifid_uses_rs2 = 0, idex_mem_read = 0, ex_br_taken = 0;
    logic       imem_req = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0;
    logic       pc_load, ifid_load, idex_load, exmem_load, memwb_load, ifid_flush, idex_flush;
    logic [1:0] stall_state;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_mem_stall, perf_lu_bubble, perf_flush;
`endif

    int total = 0;
    int bad = 0;

    // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
    localparam logic [6:0] ALL  = 7'b11111_00;
    localparam logic [6:0] FRZ  = 7'b00000_00;
    localparam logic [6:0] FLSH = 7'b11111_11;
    localparam logic [6:0] BUB  = 7'b00111_01;

    logic [6:0] obsVec;
    assign obsVec = {pc_load, ifid_load, idex_load, exmem_load, memwb_load, ifid_flush, idex_flush};

    hazard_ctrl #(.REG_ADDR_W(5), .PERF_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_uses_rs1(ifid_uses_rs1), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ex_br_taken(ex_br_taken),
        .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
        .exmem_load(exmem_load), .memwb_load(memwb_load),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .stall_state(stall_state)
`ifdef HAZARD_PERF_EN
        ,
        .perf_mem_stall(perf_mem_stall), .perf_lu_bubble(perf_lu_bubble), .perf_flush(perf_flush)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock, then drive this cycle's inputs well clear of the edge.
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                 input logic u2, input logic mr, input logic [4:0] rd,
                                 input logic br, input logic ireq, input logic iresp,
                                 input logic dreq, input logic dresp);
        @(posedge clk);
        #1;
        ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_uses_rs1 = u1; ifid_uses_rs2 = u2;
        idex_mem_read = mr; idex_rd = rd; ex_br_taken = br;
        imem_req = ireq; imem_resp = iresp; dmem_req = dreq; dmem_resp = dresp;
        #1;
    endtask

    task automatic idle();
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input string tag, input logic [6:0] expVec, input logic [1:0] expState);
        total++;
        assert (obsVec === expVec) else begin
            bad++;
            $error("[TB] FAIL %s enables observed=%b expected=%b", tag, obsVec, expVec);
        end
        total++;
        assert (stall_state === expState) else begin
            bad++;
            $error("[TB] FAIL %s stall_state observed=%0d expected=%0d", tag, stall_state, expState);
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic checkCount(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask
`endif

    initial begin
        #12;
        checkOutput("reset", FRZ, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        idle();
        checkOutput("idle", ALL, 2'd0);

        // Load-use on rs1; the hazard pattern stays visible during LU_BUBBLE and must be masked.
        applyStimulus(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 0, 0);
        checkOutput("lu_rs1_bubble", BUB, 2'd0);
        applyStimulus(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 0, 0);
        checkOutput("lu_rs1_masked", ALL, 2'd2);
        idle();
        checkOutput("lu_rs1_after", ALL, 2'd0);

        applyStimulus(5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, 0, 0);
        checkOutput("x0_no_bubble", ALL, 2'd0);
        applyStimulus(5'd0, 5'd7, 0, 0, 1, 5'd7, 0, 0, 0, 0, 0);
        checkOutput("rs2_unused", ALL, 2'd0);
        applyStimulus(5'd0, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0, 0, 0);
        checkOutput("lu_rs2_bubble", BUB, 2'd0);
        applyStimulus(5'd3, 5'd7, 1, 1, 1, 5'd9, 0, 0, 0, 0, 0);
        checkOutput("lu_rs2_next", ALL, 2'd2);

        // Split responses: imem at cycle 2, dmem at cycle 5.
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1, 0);
        checkOutput("split_c1", FRZ, 2'd0);
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 1, 0);
        checkOutput("split_c2", FRZ, 2'd1);
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1, 0);
        checkOutput("split_c3", FRZ, 2'd1);
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1, 0);
        checkOutput("split_c4", FRZ, 2'd1);
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1, 1);
        checkOutput("split_c5_release", ALL, 2'd1);
        idle();
        checkOutput("split_after", ALL, 2'd0);

        // Redirect pending during a 3-cycle dmem stall, with a competing load-use.
        applyStimulus(5'd4, 5'd0, 1, 0, 1, 5'd4, 1, 0, 0, 1, 0);
        checkOutput("br_stall_c1", FRZ, 2'd0);
        applyStimulus(5'd4, 5'd0, 1, 0, 1, 5'd4, 1, 0, 0, 1, 0);
        checkOutput("br_stall_c2", FRZ, 2'd1);
        applyStimulus(5'd4, 5'd0, 1, 0, 1, 5'd4, 1, 0, 0, 1, 0);
        checkOutput("br_stall_c3", FRZ, 2'd1);
        applyStimulus(5'd4, 5'd0, 1, 0, 1, 5'd4, 1, 0, 0, 1, 1);
        checkOutput("br_release_flush", FLSH, 2'd1);
        idle();
        checkOutput("br_after", ALL, 2'd0);

        // Stall arriving in LU_BUBBLE must not cause a second bubble on release.
        applyStimulus(5'd6, 5'd0, 1, 0, 1, 5'd6, 0, 0, 0, 0, 0);
        checkOutput("lu_stall_bubble", BUB, 2'd0);
        applyStimulus(5'd6, 5'd0, 1, 0, 1, 5'd6, 0, 0, 0, 1, 0);
        checkOutput("lu_stall_freeze1", FRZ, 2'd2);
        applyStimulus(5'd6, 5'd0, 1, 0, 1, 5'd6, 0, 0, 0, 1, 0);
        checkOutput("lu_stall_freeze2", FRZ, 2'd1);
        applyStimulus(5'd6, 5'd0, 1, 0, 1, 5'd6, 0, 0, 0, 1, 1);
        checkOutput("lu_stall_release", ALL, 2'd1);
        idle();
        checkOutput("lu_stall_after", ALL, 2'd0);

        // Reset mid-stall with imem_done already set; it must be cleared afterwards.
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 1, 0);
        checkOutput("rst_pre_c1", FRZ, 2'd0);
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1, 0);
        checkOutput("rst_pre_c2", FRZ, 2'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_state", FRZ, 2'd0);
        imem_req = 0; dmem_req = 0;
        #1;
        checkOutput("rst_loads_low", FRZ, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 0);
        checkOutput("rst_flag_cleared", FRZ, 2'd0);
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0, 0);
        checkOutput("rst_imem_release", ALL, 2'd1);
        idle();
        checkOutput("rst_after", ALL, 2'd0);

`ifdef HAZARD_PERF_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkCount("perf_reset_stall", perf_mem_stall, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 0, 0);
        idle();
        applyStimulus(5'd0, 5'd8, 0, 1, 1, 5'd8, 0, 0, 0, 0, 0);
        idle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        end
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1, 1);
        applyStimulus(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0, 0);
        checkOutput("perf_flush_cycle", FLSH, 2'd0);
        idle();
        checkCount("perf_lu_bubble", perf_lu_bubble, 32'd2);
        checkCount("perf_mem_stall", perf_mem_stall, 32'd4);
        checkCount("perf_flush", perf_flush, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline-wide stall/bubble/flush controller for the 5-stage rv32i core.
- Complements the EX-stage forwarding unit: forwarding consumes results already in the pipeline; this block holds back consumers when a producer's value cannot yet be forwarded (load-use).
- Also freezes the pipeline on outstanding instruction/data memory accesses, and flushes wrong-path instructions on taken branches/jumps.
- Drives the load/flush enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- REG_ADDR_W, 5, register index width.
- PERF_W, 32, performance counter width (used only with HAZARD_PERF_EN).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- ifid_rs1  in  REG_ADDR_W  rs1 index of instruction in ID.
- ifid_rs2  in  REG_ADDR_W  rs2 index of instruction in ID.
- ifid_uses_rs1  in  1  ID instruction reads rs1.
- ifid_uses_rs2  in  1  ID instruction reads rs2.
- idex_mem_read  in  1  instruction in EX is a load.
- idex_rd  in  REG_ADDR_W  rd of instruction in EX.
- ex_br_taken  in  1  EX resolved a redirect (taken branch, jal, jalr).
- imem_req  in  1  fetch access outstanding this cycle.
- imem_resp  in  1  fetch data valid.
- dmem_req  in  1  MEM stage access outstanding.
- dmem_resp  in  1  data access complete.
- pc_load, ifid_load, idex_load, exmem_load, memwb_load  out  1 each  register enables.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_flush  out  1  load NOP (bubble) into ID/EX.
- stall_state  out  2  current FSM state (RUN=0, MEM_WAIT=1, LU_BUBBLE=2).

Behaviour:
- Reset: while rst_n=0 all *_load=0 and both flushes=0. The FSM enters RUN, and the sticky flags imem_done and dmem_done clear to 0.
- Ready terms:
  - i_rdy = !imem_req | imem_resp | imem_done.
  - d_rdy = !dmem_req | dmem_resp | dmem_done.
  - mem_stall = !(i_rdy & d_rdy).
- Sticky flags handle responses that arrive on different cycles:
  - imem_done sets on imem_resp & mem_stall.
  - dmem_done sets on dmem_resp & mem_stall.
  - Both clear on any cycle with mem_stall=0.
- lu_hazard = idex_mem_read & idex_rd!=0 & ((ifid_uses_rs1 & ifid_rs1==idex_rd) | (ifid_uses_rs2 & ifid_rs2==idex_rd)).
- Priority: mem_stall > ex_br_taken > lu_hazard.
- mem_stall: all five loads=0 and flushes=0 (full freeze). The state goes to MEM_WAIT and stays there while mem_stall holds.
- Leaving MEM_WAIT: on the first cycle mem_stall=0, the cycle is evaluated as RUN in the same cycle, with no extra latency.
- ex_br_taken (no mem_stall): all loads=1, ifid_flush=1, idex_flush=1, and lu_hazard is ignored. This gives a 2-instruction penalty. Because EX is frozen during a stall, a redirect that is pending during mem_stall is applied on the release cycle.
- lu_hazard (no mem_stall, no redirect):
  - pc_load=0, ifid_load=0.
  - idex_load=1 with idex_flush=1, inserting exactly one bubble.
  - exmem_load=1, memwb_load=1.
  - State goes to LU_BUBBLE for one cycle.
- In LU_BUBBLE, hazard detection is masked: the ID instruction advances on the next non-stalled cycle, and the load result is then forwarded from MEM/WB.
  - If mem_stall arises during LU_BUBBLE, the state goes to MEM_WAIT and a flag remembers that the bubble was already inserted, so no second bubble is issued on release.
- Otherwise all loads=1 and flushes=0.
- rst_n falling mid-stall aborts immediately to the reset values above. Outputs are combinational from state plus inputs; all state registers use async reset.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, three additional outputs are present:
  - perf_mem_stall  out  PERF_W  increments each mem_stall cycle.
  - perf_lu_bubble  out  PERF_W  increments each bubble inserted.
  - perf_flush  out  PERF_W  increments each redirect flush.
- Counters saturate at all-ones and reset to 0.
- When undefined, these ports and counters are absent and the other behaviour is unchanged.

Test Plan:
- Load-use: idex_mem_read=1, idex_rd=5, ifid_rs1=5, ifid_uses_rs1=1 → one cycle of pc_load=0, ifid_load=0, idex_flush=1, stall_state=2; next cycle all loads=1.
- x0 and non-use cases: idex_rd=0, ifid_rs1=0 → no bubble. idex_rd=7, ifid_rs2=7, ifid_uses_rs2=0 → no bubble.
- Split memory responses: imem_req=dmem_req=1; imem_resp pulses at cycle 2, dmem_resp at cycle 5 → freeze through cycle 4, stall_state=1, all loads=1 at cycle 5; imem_done observed set during cycles 3-4.
- Redirect under stall: ex_br_taken=1 with dmem pending 3 cycles → freeze 3 cycles, then one cycle with ifid_flush=idex_flush=1 and loads=1; a simultaneous lu_hazard is ignored.
- Reset mid-stall: rst_n=0 during MEM_WAIT → loads=0 immediately (async); after release, stall_state=0 and the flags are clear.
- HAZARD_PERF_EN: 2 bubbles, 4 stall cycles, 1 flush → perf_lu_bubble=2, perf_mem_stall=4, perf_flush=1.
